// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MUL, restoring DIV/REM.
// Optional `MULDIV_EARLY_OUT_EN finishes zero-operand ops in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;
  logic             rem_q, rem_d;
  logic             skip_q, skip_d;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] mul_sum;
  logic             last;
  logic             opb_zero;
  logic             early_mul;
  logic             early_div;

  // a_q doubles as multiplicand / quotient, p_q as accumulator / remainder
  assign shifted  = {p_q, a_q[WIDTH-1]};
  assign fits     = shifted >= {1'b0, b_q};
  assign diff     = shifted[WIDTH-1:0] - b_q;
  assign rem_nxt  = fits ? diff : shifted[WIDTH-1:0];
  assign quo_nxt  = {a_q[WIDTH-2:0], fits};
  assign mul_sum  = p_q + (b_q[0] ? a_q : '0);
  assign last     = cnt_q == CNT_W'(1);
  assign opb_zero = opb == '0;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_mul = (opa == '0) || opb_zero;
  assign early_div = opa == '0;
`else
  assign early_mul = 1'b0;
  assign early_div = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      rem_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      rem_q   <= rem_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    rem_d   = rem_q;
    skip_d  = skip_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = opa;
          b_d    = opb;
          p_d    = '0;
          cnt_d  = CNT_W'(WIDTH);
          rem_d  = op[1];
          dbz_d  = 1'b0;
          skip_d = 1'b0;
          res_d  = '0;
          state_d = S_DIV;
          // Skipped ops preload the result and spend a single cycle
          if (op == 2'b11) begin
            skip_d = 1'b1;
            cnt_d  = CNT_W'(1);
          end else if (op == 2'b00) begin
            state_d = S_MUL;
            if (early_mul) begin
              skip_d = 1'b1;
              cnt_d  = CNT_W'(1);
            end
          end else if (opb_zero) begin
            skip_d = 1'b1;
            dbz_d  = 1'b1;
            cnt_d  = CNT_W'(1);
            res_d  = op[1] ? opa : '1;
          end else if (early_div) begin
            skip_d = 1'b1;
            cnt_d  = CNT_W'(1);
          end
        end
      end
      S_MUL: begin
        p_d   = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          state_d = S_DONE;
          if (!skip_q) res_d = mul_sum;
        end
      end
      S_DIV: begin
        p_d   = rem_nxt;
        a_d   = quo_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          state_d = S_DONE;
          if (!skip_q) res_d = rem_q ? rem_nxt : quo_nxt;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = state_q == S_IDLE;
    out_valid   = state_q == S_DONE;
    result      = res_q;
    div_by_zero = dbz_q;
  end

endmodule
